program_mem_controller: RTL and testbench

- Arbitrates program-memory reads from NUM_CONSUMERS per-core fetch units onto one external program-memory read port.
- Each consumer port uses the fetch valid/ready protocol:
  - consumer raises valid with the address held stable;
  - the controller answers with a one-cycle ready pulse carrying the data;
  - the consumer drops valid on a later cycle.
- Round-robin arbitration; one outstanding memory read at a time.

---
 rtl/program_mem_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/program_mem_controller.sv | 98 +++++++++
 tb/tb_program_mem_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_mem_pkg.sv
// Shared types and helpers for the program-memory read controller.
package program_mem_pkg;

   // Controller sequencing: pick a consumer, wait for memory, hand data back.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } pmc_state_t;

   // Width of an index into n consumers; never less than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after pointer.
module rr_arbiter
   import program_mem_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] request,
   input  logic [IDX_W-1:0]   pointer,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest hit to pointer wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         cand = IDX_W'((32'(pointer) + 32'(k)) % NUM_REQ);
         if (request[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

endmodule

// File: rtl/program_mem_controller.sv
// Round-robin arbiter of per-core fetch reads onto one program-memory port.
// One read is outstanding at a time; every output is registered.
module program_mem_controller
   import program_mem_pkg::*;
#(
   parameter int unsigned NUM_CONSUMERS = 4,
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 16
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   output logic                                    mem_read_valid,
   output logic [ADDR_BITS-1:0]                    mem_read_address,
   input  logic                                    mem_read_ready,
   input  logic [DATA_BITS-1:0]                    mem_read_data
);

   localparam int unsigned IDX_W = idx_width(NUM_CONSUMERS);

   pmc_state_t                 state_q;
   logic [IDX_W-1:0]           grant_idx_q;
   logic [IDX_W-1:0]           rr_ptr_q;
   logic [NUM_CONSUMERS-1:0]   served_q;
   logic [DATA_BITS-1:0]       data_q;

   logic [NUM_CONSUMERS-1:0]   eligible;
   logic [IDX_W-1:0]           arb_idx;
   logic                       arb_any;

   // A consumer already answered is masked until it lowers valid, so the
   // trailing valid a fetcher holds after ready cannot start a second read.
   assign eligible = consumer_read_valid & ~served_q;

   rr_arbiter #(
      .NUM_REQ (NUM_CONSUMERS),
      .IDX_W   (IDX_W)
   ) u_arb (
      .request   (eligible),
      .pointer   (rr_ptr_q),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   // Sequencer with registered outputs; reset abandons any in-flight read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q             <= IDLE;
         grant_idx_q         <= '0;
         rr_ptr_q            <= '0;
         served_q            <= '0;
         data_q              <= '0;
         mem_read_valid      <= 1'b0;
         mem_read_address    <= '0;
         consumer_read_ready <= '0;
         consumer_read_data  <= '0;
      end else begin
         consumer_read_ready <= '0;
         for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
            if (!consumer_read_valid[i]) begin
               served_q[i] <= 1'b0;
            end
         end

         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  grant_idx_q      <= arb_idx;
                  mem_read_valid   <= 1'b1;
                  mem_read_address <= consumer_read_address[arb_idx];
                  state_q          <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_read_ready) begin
                  data_q         <= mem_read_data;
                  mem_read_valid <= 1'b0;
                  state_q        <= RESPOND;
               end
            end
            RESPOND: begin
               consumer_read_ready[grant_idx_q] <= 1'b1;
               consumer_read_data[grant_idx_q]  <= data_q;
               // Set wins over the clear above, even if valid was dropped early.
               served_q[grant_idx_q]            <= 1'b1;
               rr_ptr_q <= (grant_idx_q == IDX_W'(NUM_CONSUMERS - 1)) ?
                           '0 : grant_idx_q + IDX_W'(1);
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_mem_controller.sv
// Self-checking bench: consumer and memory models, scoreboard of expected
// responses, a vector table plus hand-written reset/latency sequences.
module tb_program_mem_controller;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [3:0]        c_valid = '0;
   logic [3:0][7:0]   c_addr = '0;
   logic [3:0]        c_ready;
   logic [3:0][15:0]  c_data;
   logic              mem_read_valid;
   logic [7:0]        mem_read_address;
   logic              mem_read_ready = 1'b0;
   logic [15:0]       mem_read_data = '0;

   program_mem_controller #(
      .NUM_CONSUMERS (4),
      .ADDR_BITS     (8),
      .DATA_BITS     (16)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .consumer_read_valid   (c_valid),
      .consumer_read_address (c_addr),
      .consumer_read_ready   (c_ready),
      .consumer_read_data    (c_data),
      .mem_read_valid        (mem_read_valid),
      .mem_read_address      (mem_read_address),
      .mem_read_ready        (mem_read_ready),
      .mem_read_data         (mem_read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [15:0] data;
   } exp_t;

   typedef struct {
      logic [3:0][3:0] reqs;
      logic [3:0][7:0] addr;
      int              wait_c;
      int              n_exp;
      logic [7:0][1:0] order;
   } vec_t;

   exp_t     q[$];
   vec_t     vecs[6];
   int       n_checks = 0;
   int       n_err = 0;
   int       cyc = 0;
   int       issues = 0;
   int       total_pulses = 0;
   int       mem_wait = 0;
   int       spurious = 0;
   int       reqs_left[4];
   int       phase[4];
   int       raise_cyc[4];
   int       latency[4];
   int       pulses[4];
   logic [7:0] addr_r[4];
   logic     prev_mv = 1'b0;
   logic     mem_busy = 1'b0;
   int       mem_cnt = 0;
   logic [7:0] mem_hold = '0;

   function automatic logic [15:0] mem_fn(input logic [7:0] a);
      if (a == 8'h1A) return 16'hBEEF;
      return {~a, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic all_idle();
      logic r;
      r = (q.size() == 0) && !mem_read_valid;
      for (int i = 0; i < 4; i++) r = r && (reqs_left[i] == 0) && (phase[i] == 0);
      return r;
   endfunction

   task automatic drain();
      int budget;
      budget = 0;
      while (!all_idle() && budget < 400) begin
         @(posedge clk);
         budget++;
      end
      check("drain_timeout", 64'(budget >= 400), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_valid"}, 64'(mem_read_valid), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_read_address), 64'd0);
      check({tag, "_ready"}, 64'(c_ready), 64'd0);
      check({tag, "_data"}, c_data, 64'd0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor, memory model and consumer model, all away from the rising edge.
   initial begin
      for (int i = 0; i < 4; i++) begin
         reqs_left[i] = 0; phase[i] = 0; raise_cyc[i] = 0;
         latency[i] = 0; pulses[i] = 0; addr_r[i] = '0;
      end
      forever begin
         @(negedge clk);
         // scoreboard
         if (c_ready != 4'b0) check("ready_onehot", 64'($countones(c_ready)), 64'd1);
         for (int i = 0; i < 4; i++) begin
            if (c_ready[i]) begin
               exp_t e;
               pulses[i]++;
               total_pulses++;
               latency[i] = cyc - raise_cyc[i];
               if (q.size() == 0) begin
                  check("unexpected_ready", 64'(i), 64'hFF);
               end else begin
                  e = q.pop_front();
                  check("grant_order", 64'(i), 64'(e.idx));
                  check("resp_data", 64'(c_data[i]), 64'(e.data));
               end
            end
         end
         if (mem_read_valid && !prev_mv) issues++;
         prev_mv = mem_read_valid;
         // memory
         if (!reset) begin
            mem_busy = 1'b0;
            mem_read_ready = 1'b0;
         end else if (spurious > 0) begin
            mem_read_ready = 1'b1;
            mem_read_data = 16'hDEAD;
            spurious--;
         end else if (mem_read_ready) begin
            mem_read_ready = 1'b0;
         end else if (mem_read_valid) begin
            if (!mem_busy) begin
               mem_busy = 1'b1;
               mem_cnt = mem_wait;
               mem_hold = mem_read_address;
            end else begin
               check("mem_addr_stable", 64'(mem_read_address), 64'(mem_hold));
            end
            if (mem_cnt == 0) begin
               mem_read_ready = 1'b1;
               mem_read_data = mem_fn(mem_hold);
               mem_busy = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
         // consumers: hold valid one cycle past ready, then low for one cycle
         for (int i = 0; i < 4; i++) begin
            case (phase[i])
               0: if (reqs_left[i] > 0 && reset) begin
                  c_valid[i] = 1'b1;
                  c_addr[i] = addr_r[i];
                  raise_cyc[i] = cyc;
                  phase[i] = 1;
               end
               1: if (c_ready[i]) phase[i] = 2;
               default: begin
                  c_valid[i] = 1'b0;
                  reqs_left[i]--;
                  phase[i] = 0;
               end
            endcase
         end
      end
   end

   initial begin
      exp_t e;
      int   p0;
      int   budget;
      // {c3,c2,c1,c0} request counts and addresses; order lists grant sequence
      vecs[0] = '{reqs: {4'd1, 4'd0, 4'd1, 4'd1}, addr: {8'h13, 8'h00, 8'h11, 8'h10},
                  wait_c: 0, n_exp: 3, order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0}};
      vecs[1] = vecs[0];
      vecs[2] = '{reqs: {4'd0, 4'd0, 4'd1, 4'd2}, addr: {8'h00, 8'h00, 8'h21, 8'h20},
                  wait_c: 0, n_exp: 3, order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0}};
      vecs[3] = '{reqs: {4'd0, 4'd1, 4'd0, 4'd0}, addr: {8'h00, 8'h2C, 8'h00, 8'h00},
                  wait_c: 5, n_exp: 1, order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};
      vecs[4] = '{reqs: {4'd1, 4'd1, 4'd1, 4'd1}, addr: {8'h43, 8'h42, 8'h41, 8'h40},
                  wait_c: 1, n_exp: 4, order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3}};
      vecs[5] = '{reqs: {4'd0, 4'd1, 4'd1, 4'd0}, addr: {8'h00, 8'h52, 8'h51, 8'h00},
                  wait_c: 2, n_exp: 2, order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1}};

      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("por");
      @(negedge clk) reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single request, zero-wait memory, trailing valid must not re-issue
      issues = 0;
      mem_wait = 0;
      addr_r[2] = 8'h1A;
      q.push_back('{idx: 2, data: 16'hBEEF});
      reqs_left[2] = 1;
      drain();
      check("single_latency", 64'(latency[2]), 64'd3);
      check("single_pulses", 64'(pulses[2]), 64'd1);
      check("single_issues", 64'(issues), 64'd1);

      // reset pointer back to 0 before the table
      reset = 1'b0;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) begin
         issues = 0;
         mem_wait = vecs[v].wait_c;
         for (int k = 0; k < vecs[v].n_exp; k++) begin
            e.idx = int'(vecs[v].order[k]);
            e.data = mem_fn(vecs[v].addr[vecs[v].order[k]]);
            q.push_back(e);
         end
         for (int i = 0; i < 4; i++) begin
            addr_r[i] = vecs[v].addr[i];
            reqs_left[i] = int'(vecs[v].reqs[i]);
         end
         drain();
         check($sformatf("vec%0d_issues", v), 64'(issues), 64'(vecs[v].n_exp));
      end

      // reset in the middle of a long memory wait
      mem_wait = 10;
      addr_r[1] = 8'h55;
      q.push_back('{idx: 1, data: mem_fn(8'h55)});
      reqs_left[1] = 1;
      budget = 0;
      while (!mem_read_valid && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      check("midread_issue_timeout", 64'(budget >= 20), 64'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset_outputs("midread");
      for (int i = 0; i < 4; i++) begin
         reqs_left[i] = 0;
         phase[i] = 0;
         c_valid[i] = 1'b0;
      end
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;

      // stale/spurious memory strobes in IDLE must be ignored
      p0 = total_pulses;
      issues = 0;
      spurious = 2;
      repeat (6) @(posedge clk);
      #1;
      check("stale_no_ready", 64'(total_pulses - p0), 64'd0);
      check("stale_no_issue", 64'(issues), 64'd0);
      check("stale_mem_valid", 64'(mem_read_valid), 64'd0);

      // fresh requests after reset: pointer restarts at 0
      mem_wait = 0;
      addr_r[0] = 8'h60;
      addr_r[3] = 8'h63;
      q.push_back('{idx: 0, data: mem_fn(8'h60)});
      q.push_back('{idx: 3, data: mem_fn(8'h63)});
      reqs_left[0] = 1;
      reqs_left[3] = 1;
      drain();
      check("post_reset_issues", 64'(issues), 64'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
